// File: rtl/arb_pkg.sv
// Shared arbitration constants for the registered N-way selector.
// Mode encodings plus a clog2 helper for toolflows without $clog2.
package arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Request/response bundle for rr_arb_mux: N requester channels in, one consumer out.
// Both sides use valid/ready; the slave modport is the arbiter's view.
interface rr_arb_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping.
// Zero latency; no handshake of its own.
module rr_grant #(
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              any
);

  logic [2*NUM_IN-1:0] req_dbl;
  logic [NUM_IN-1:0]   rot;
  logic [SEL_W-1:0]    off;
  logic [SEL_W:0]      sum;

  assign req_dbl = {req, req};

  // Rotating the doubled vector puts the ptr channel at bit 0 without wrap logic.
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      rot[i] = req_dbl[32'(ptr) + i];
    end
  end

  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (SEL_W + 1)'(NUM_IN)) begin
      sum = sum - (SEL_W + 1)'(NUM_IN);
    end
    gnt_idx = sum[SEL_W-1:0];
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      grant[i] = any && (gnt_idx == SEL_W'(i));
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way round-robin / fixed-select mux into a single output register, 1 cycle latency.
// in_ready only when the register is empty or draining this cycle; full throughput.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input logic         clk,
  input logic         rstn,
  rr_arb_mux_if.slave bus
);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;

  logic [NUM_IN-1:0] rr_grant_w, fix_grant, grant;
  logic [SEL_W-1:0]  rr_idx, win_idx;
  logic              rr_any, fix_any, win_any;
  logic              load, xfer;
  logic [WIDTH-1:0]  win_data;

  rr_grant #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_rr_grant (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .grant   (rr_grant_w),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // Loop compare keeps an out-of-range sel harmless: it simply matches no channel.
  always_comb begin
    fix_grant = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      fix_grant[i] = bus.in_valid[i] && (bus.sel == SEL_W'(i));
    end
    fix_any = |fix_grant;
  end

  always_comb begin
    if (bus.mode == MODE_FIXED) begin
      grant   = fix_grant;
      win_idx = bus.sel;
      win_any = fix_any;
    end else begin
      grant   = rr_grant_w;
      win_idx = rr_idx;
      win_any = rr_any;
    end
  end

  assign load         = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = (rstn && load && win_any) ? grant : '0;
  assign xfer         = |bus.in_ready;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant[i]) win_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = win_data;
      out_src_d   = win_idx;
      if (bus.mode == MODE_RR) begin
        ptr_d = (win_idx == SEL_W'(NUM_IN - 1)) ? '0 : win_idx + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
